ipm_distributed_fifo_sizedown_v1_3: RTL and testbench

Single-clock FIFO on distributed SDP RAM with built-in width down-conversion: accepts RATIO×RD_WIDTH-bit words, returns RD_WIDTH-bit words, least-significant lane first. Supersedes the bare distributed SDP RAM plus external pointer logic in the size-down path. Adds full/empty, almost flags, two-domain levels, overflow/underflow detection and an optional output register.

---
 rtl/ipm_distributed_fifo_sizedown_v1_3.sv | 159 +++++++++++++++
 tb/tb_ipm_distributed_fifo_sizedown_v1_3.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipm_distributed_fifo_sizedown_v1_3.sv
// Single-clock FIFO on distributed RAM that accepts RATIO*RD_WIDTH-bit words and
// returns RD_WIDTH-bit words, least-significant lane first.
module ipm_distributed_fifo_sizedown_v1_3 #(
  parameter int ADDR_WIDTH       = 4,
  parameter int RD_WIDTH         = 8,
  parameter int RATIO            = 4,
  parameter int OUT_REG          = 0,
  parameter int ALMOST_FULL_NUM  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [RD_WIDTH*RATIO-1:0]    wr_data,
  output logic                         wr_full,
  output logic                         almost_full,
  output logic [ADDR_WIDTH:0]          wr_level,
  output logic                         overflow,
  input  logic                         rd_en,
  output logic [RD_WIDTH-1:0]          rd_data,
  output logic                         rd_valid,
  output logic                         rd_empty,
  output logic                         almost_empty,
  output logic [ADDR_WIDTH+3:0]        rd_level,
  output logic                         underflow
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int WR_WIDTH  = RD_WIDTH * RATIO;
  localparam int PTR_W     = ADDR_WIDTH + 1;
  localparam int LVL_W     = ADDR_WIDTH + 4;
  localparam int LANE_BITS = (RATIO > 1) ? $clog2(RATIO) : 0;
  localparam int LANE_W    = (RATIO > 1) ? LANE_BITS : 1;

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  DEPTH_L   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]  AF_NUM    = PTR_W'(ALMOST_FULL_NUM);
  localparam logic [LVL_W-1:0]  AE_NUM    = LVL_W'(ALMOST_EMPTY_NUM);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [PTR_W-1:0]    r_wp;
  logic [PTR_W-1:0]    r_rp;
  logic [LANE_W-1:0]   r_lane;
  logic                r_overflow;
  logic                r_underflow;
  logic [RD_WIDTH-1:0] r_rd_data;
  logic                r_rd_valid;
  logic [WR_WIDTH-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0]    w_wr_level;
  logic [LVL_W-1:0]    w_rd_level;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_lane_last;
  logic [WR_WIDTH-1:0] w_entry;
  logic [RD_WIDTH-1:0] w_lane_data;

  // Flags decode only registered pointers, so an asynchronous reset clears them at once.
  assign w_wr_level  = r_wp - r_rp;
  assign w_full      = (w_wr_level == DEPTH_L);
  assign w_empty     = (r_wp == r_rp);
  assign w_rd_level  = (LVL_W'(w_wr_level) << LANE_BITS) - LVL_W'(r_lane);
  assign w_wr_acc    = wr_en & ~w_full;
  assign w_rd_acc    = rd_en & ~w_empty;
  assign w_lane_last = (r_lane == LAST_LANE);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_lane      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
      if (w_wr_acc) begin
        r_wp <= r_wp + PTR_ONE;
      end
      if (w_rd_acc) begin
        if (w_lane_last) begin
          r_lane <= '0;
          r_rp   <= r_rp + PTR_ONE;
        end else begin
          r_lane <= r_lane + LANE_ONE;
        end
      end
    end
  end

  // NOTE: the storage array has no reset so it maps onto distributed RAM; the
  // pointers guarantee no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_entry     = r_mem[r_rp[ADDR_WIDTH-1:0]];
    w_lane_data = w_entry[RD_WIDTH-1:0];
    for (int k = 0; k < RATIO; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_lane_data = w_entry[k*RD_WIDTH +: RD_WIDTH];
      end
    end
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_lane_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [RD_WIDTH-1:0] r_rd_data_q;
      logic                r_rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data_q  <= '0;
          r_rd_valid_q <= 1'b0;
        end else begin
          r_rd_data_q  <= r_rd_data;
          r_rd_valid_q <= r_rd_valid;
        end
      end

      assign rd_data  = r_rd_data_q;
      assign rd_valid = r_rd_valid_q;
    end else begin : g_no_out_reg
      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  assign wr_full      = w_full;
  assign almost_full  = (w_wr_level >= AF_NUM);
  assign wr_level     = w_wr_level;
  assign overflow     = r_overflow;
  assign rd_empty     = w_empty;
  assign almost_empty = (w_rd_level <= AE_NUM);
  assign rd_level     = w_rd_level;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_ipm_distributed_fifo_sizedown_v1_3.sv
// Bench for the size-down FIFO: two instances (OUT_REG=0 and OUT_REG=1) share stimulus
// and are compared each cycle against a narrow-word queue model.
module tb_ipm_distributed_fifo_sizedown_v1_3;

  localparam int AW    = 4;
  localparam int RW    = 8;
  localparam int R     = 4;
  localparam int WW    = RW * R;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [WW-1:0] wr_data = '0;

  logic          wr_full [2];
  logic          almost_full [2];
  logic [AW:0]   wr_level [2];
  logic          overflow [2];
  logic [RW-1:0] rd_data [2];
  logic          rd_valid [2];
  logic          rd_empty [2];
  logic          almost_empty [2];
  logic [AW+3:0] rd_level [2];
  logic          underflow [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ipm_distributed_fifo_sizedown_v1_3 #(
    .ADDR_WIDTH(AW), .RD_WIDTH(RW), .RATIO(R), .OUT_REG(0),
    .ALMOST_FULL_NUM(DEPTH - 2), .ALMOST_EMPTY_NUM(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full[0]), .almost_full(almost_full[0]), .wr_level(wr_level[0]),
    .overflow(overflow[0]), .rd_en(rd_en), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .rd_empty(rd_empty[0]), .almost_empty(almost_empty[0]), .rd_level(rd_level[0]),
    .underflow(underflow[0])
  );

  ipm_distributed_fifo_sizedown_v1_3 #(
    .ADDR_WIDTH(AW), .RD_WIDTH(RW), .RATIO(R), .OUT_REG(1),
    .ALMOST_FULL_NUM(DEPTH - 2), .ALMOST_EMPTY_NUM(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full[1]), .almost_full(almost_full[1]), .wr_level(wr_level[1]),
    .overflow(overflow[1]), .rd_en(rd_en), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .rd_empty(rd_empty[1]), .almost_empty(almost_empty[1]), .rd_level(rd_level[1]),
    .underflow(underflow[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO as a queue of narrow words in output order.
  logic [RW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_valid2 = 1'b0;
  logic [RW-1:0] m_data = '0;
  logic [RW-1:0] m_data2 = '0;

  function automatic int m_wide();
    return (mq.size() + R - 1) / R;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      m_valid = 1'b0; m_valid2 = 1'b0;
      m_data = '0; m_data2 = '0;
    end else begin
      bit full_now, empty_now;
      full_now  = (m_wide() == DEPTH);
      empty_now = (mq.size() == 0);
      m_ovf     = wr_en && full_now;
      m_unf     = rd_en && empty_now;
      m_valid2  = m_valid;
      m_data2   = m_data;
      m_valid   = 1'b0;
      if (rd_en && !empty_now) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end
      if (wr_en && !full_now) begin
        for (int k = 0; k < R; k++) mq.push_back(wr_data[k*RW +: RW]);
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("cyc_wr_full%0d", d),      64'(wr_full[d]),      64'(m_wide() == DEPTH));
      check($sformatf("cyc_almost_full%0d", d),  64'(almost_full[d]),  64'(m_wide() >= DEPTH - 2));
      check($sformatf("cyc_wr_level%0d", d),     64'(wr_level[d]),     64'(m_wide()));
      check($sformatf("cyc_overflow%0d", d),     64'(overflow[d]),     64'(m_ovf));
      check($sformatf("cyc_rd_empty%0d", d),     64'(rd_empty[d]),     64'(mq.size() == 0));
      check($sformatf("cyc_almost_empty%0d", d), 64'(almost_empty[d]), 64'(mq.size() <= 2));
      check($sformatf("cyc_rd_level%0d", d),     64'(rd_level[d]),     64'(mq.size()));
      check($sformatf("cyc_underflow%0d", d),    64'(underflow[d]),    64'(m_unf));
      check($sformatf("cyc_rd_valid%0d", d),     64'(rd_valid[d]),     64'(d == 0 ? m_valid : m_valid2));
      check($sformatf("cyc_rd_data%0d", d),      64'(rd_data[d]),      64'(d == 0 ? m_data : m_data2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] fill_word(input int i);
    logic [WW-1:0] w;
    for (int k = 0; k < R; k++) w[k*RW +: RW] = 8'(i * R + k);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [RW-1:0] lane_exp [4];
  logic [AW+3:0] lvl_exp  [4];
  int empty_hits, ovf_hits, unf_hits;

  initial begin
    lane_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    lvl_exp  = '{8'd3, 8'd2, 8'd1, 8'd0};

    // Reset state, checked while reset is held.
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd_empty",     64'(rd_empty[0]),     64'd1);
    check("rst_almost_empty", 64'(almost_empty[0]), 64'd1);
    check("rst_wr_full",      64'(wr_full[0]),      64'd0);
    check("rst_almost_full",  64'(almost_full[0]),  64'd0);
    check("rst_wr_level",     64'(wr_level[0]),     64'd0);
    check("rst_rd_valid",     64'(rd_valid[0]),     64'd0);
    check("rst_rd_data1",     64'(rd_data[1]),      64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Read while empty.
    rd_en = 1'b1;
    step();
    check("unf_pulse",    64'(underflow[0]), 64'd1);
    check("unf_rd_empty", 64'(rd_empty[0]),  64'd1);
    check("unf_rd_valid", 64'(rd_valid[0]),  64'd0);
    check("unf_rd_data",  64'(rd_data[0]),   64'h00);
    rd_en = 1'b0;
    step();
    check("unf_once", 64'(underflow[0]), 64'd0);

    // Lane order.
    wr_en = 1'b1; wr_data = 32'h44332211;
    step();
    wr_en = 1'b0;
    check("lane_wr_level0", 64'(wr_level[0]), 64'd1);
    check("lane_rd_level0", 64'(rd_level[0]), 64'd4);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("lane_data%0d", i),  64'(rd_data[0]),  64'(lane_exp[i]));
      check($sformatf("lane_valid%0d", i), 64'(rd_valid[0]), 64'd1);
      check($sformatf("lane_rdlvl%0d", i), 64'(rd_level[0]), 64'(lvl_exp[i]));
      check($sformatf("lane_wrlvl%0d", i), 64'(wr_level[0]), (i < 3) ? 64'd1 : 64'd0);
    end
    rd_en = 1'b0;

    // Fill and overflow.
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = fill_word(i);
      step();
    end
    check("fill_full",     64'(wr_full[0]),     64'd1);
    check("fill_af",       64'(almost_full[0]), 64'd1);
    check("fill_wr_level", 64'(wr_level[0]),    64'd16);
    check("fill_rd_level", 64'(rd_level[0]),    64'd64);
    wr_data = 32'hBADBADBA;
    step();
    check("ovf_pulse",    64'(overflow[0]), 64'd1);
    check("ovf_wr_level", 64'(wr_level[0]), 64'd16);
    wr_en = 1'b0; rd_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("full_rd%0d", j), 64'(rd_data[0]), 64'(j));
    end
    check("ovf_once", 64'(overflow[0]), 64'd0);

    // Simultaneous write and read at full with lane = 3.
    wr_en = 1'b1; wr_data = 32'h5A5A5A5A;
    step();
    wr_en = 1'b0;
    check("sim_rd_data",  64'(rd_data[0]),  64'd3);
    check("sim_overflow", 64'(overflow[0]), 64'd1);
    check("sim_wr_level", 64'(wr_level[0]), 64'd15);
    check("sim_rd_level", 64'(rd_level[0]), 64'd60);
    for (int j = 4; j < 64; j++) begin
      step();
      check($sformatf("drain_rd%0d", j), 64'(rd_data[0]), 64'(j));
    end
    rd_en = 1'b0;
    check("drain_empty", 64'(rd_empty[0]), 64'd1);
    check("drain_level", 64'(wr_level[0]), 64'd0);

    // Streaming: one wide write every 4th cycle, one narrow read every cycle.
    empty_hits = 0; ovf_hits = 0; unf_hits = 0;
    for (int c = 0; c < 1000; c++) begin
      wr_en   = (c % 4 == 0);
      wr_data = fill_word(64 + c / 4);
      rd_en   = (c >= 1);
      step();
      if (rd_empty[0]) empty_hits++;
      if (overflow[0]) ovf_hits++;
      if (underflow[0]) unf_hits++;
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 40 && !rd_empty[0]; k++) step();
    rd_en = 1'b0;
    check("stream_empty_hits", 64'(empty_hits), 64'd0);
    check("stream_overflows",  64'(ovf_hits),   64'd0);
    check("stream_underflows", 64'(unf_hits),   64'd0);
    check("stream_drained",    64'(rd_empty[0]), 64'd1);

    // OUT_REG latency comparison.
    wr_en = 1'b1; wr_data = 32'h87654321;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("lat1_valid0", 64'(rd_valid[0]), 64'd1);
    check("lat1_data0",  64'(rd_data[0]),  64'h21);
    check("lat1_valid1", 64'(rd_valid[1]), 64'd0);
    step();
    check("lat2_valid1", 64'(rd_valid[1]), 64'd1);
    check("lat2_data1",  64'(rd_data[1]),  64'h21);
    check("lat2_valid0", 64'(rd_valid[0]), 64'd0);

    // Reset in the middle of a read burst.
    rd_en = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    rd_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mrst_valid%0d", d), 64'(rd_valid[d]), 64'd0);
      check($sformatf("mrst_empty%0d", d), 64'(rd_empty[d]), 64'd1);
      check($sformatf("mrst_data%0d", d),  64'(rd_data[d]),  64'd0);
      check($sformatf("mrst_level%0d", d), 64'(rd_level[d]), 64'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    wr_en = 1'b1; wr_data = 32'h0F0E0D0C;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_rst_data0", 64'(rd_data[0]), 64'h0C);
    step();
    check("post_rst_data1",  64'(rd_data[1]),  64'h0C);
    check("post_rst_valid1", 64'(rd_valid[1]), 64'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
